cv32e40p_register_file_mp: RTL and testbench
============================================

Name: cv32e40p_register_file_mp

Overview:
- Flip-flop based, multi-port integer/FP register file for the cv32e40p pipeline.
- Supports a configurable number of read and write ports.
- Supports register-pair (64-bit) reads and writes, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- The ID stage uses the scoreboard for hazard stalls when multiple write-back sources (ALU, LSU, multi-cycle units) retire out of order.

Parameters:
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP bank when FPU=1 and PULP_ZFINX=0.
- DATA_WIDTH, 32: register width.
- FPU, 0: 1 instantiates the 32-entry FP bank.
- PULP_ZFINX, 0: 1 means FP operands use the integer bank; no FP bank is instantiated.
- NUM_RPORTS, 3: number of read ports.
- NUM_WPORTS, 2: number of write ports; a higher index has higher priority.
- BYPASS, 0: 1 means read data reflects same-cycle writes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- raddr_i  in  NUM_RPORTS x ADDR_WIDTH  read addresses
- rdata_o  out  NUM_RPORTS x DATA_WIDTH  data at raddr
- rdata_hi_o  out  NUM_RPORTS x DATA_WIDTH  data at raddr+1, same bank
- rbusy_o  out  NUM_RPORTS  busy bit of raddr, OR'd with busy of raddr+1 when rpair_i set
- rpair_i  in  NUM_RPORTS  read is a pair read
- waddr_i  in  NUM_WPORTS x ADDR_WIDTH  write addresses
- wdata_i  in  NUM_WPORTS x DATA_WIDTH  low write data
- wdata_hi_i  in  NUM_WPORTS x DATA_WIDTH  high write data, pair writes only
- we_i  in  NUM_WPORTS  write enable
- wpair_i  in  NUM_WPORTS  pair write: waddr gets wdata, waddr+1 gets wdata_hi
- res_valid_i  in  1  reserve destination(s) in scoreboard
- res_addr_i  in  ADDR_WIDTH  reserved destination
- res_pair_i  in  1  also reserve res_addr+1
- pair_err_o  out  1  registered; pulses when any pair access wraps past entry 31 of its bank

Behaviour:
- Reset: all registers read 0; all busy bits 0; pair_err_o=0.
- Index 0 of the integer bank is hard-wired to 0: writes dropped, busy never set. FP entry 0 is a normal register.
- Bank/offset: with the FP bank present, addr[5] selects the bank and addr[4:0] is the offset. Otherwise addr[4:0] only.
- "+1" is offset+1 within the same bank. Offset 31 plus 1 is invalid:
  - hi read returns 0.
  - hi write is dropped.
  - hi reservation is dropped.
  - pair_err_o=1 next cycle.
- Reads are combinational from storage.
  - BYPASS=1: if any enabled write targets the read address (lo or hi half), rdata returns the highest-priority matching write data in the same cycle.
  - BYPASS=0: new data is visible the cycle after the write.
- Writes take effect on posedge clk, when we_i is set.
  - Lo half: waddr receives wdata.
  - Hi half (wpair_i set): waddr+1 receives wdata_hi.
  - Per-register conflict among all lo/hi targets: the highest port index wins; within one port, lo and hi never collide.
- Scoreboard, per register, next-state priority:
  - Reserve of that register sets busy.
  - Otherwise, a write to it clears busy.
  - Otherwise, busy holds.
  - A simultaneous write-back and new reservation of the same register therefore leaves busy=1.
- Writing a register that is not busy is legal; the data updates and busy stays 0.
- rbusy_o is combinational from current busy state and does not see same-cycle reservations.
- Reset mid-operation clears storage and scoreboard immediately (asynchronous); the next edge after deassertion behaves normally.
- No latches. The ID stage is responsible for not reserving FP bank addresses when no FP bank is present; these are masked to the integer bank.

Decomposition:
- cv32e40p_pkg holds:
  - NUM_INT_REGS=32 and NUM_FP_REGS=32.
  - A function regfile_next_addr(addr) returning {valid, addr+1}, with valid cleared at the bank wrap.
- Sub-module cv32e40p_regfile_scoreboard contains the busy vector, reservation and clear logic, and rbusy lookup.
- The top contains storage, the write decoder, the bypass network and pair_err_o.

Test Plan:
- Write port 0 x5=0x1234_5678 with BYPASS=0: rdata[0] for x5 is old value in that cycle, 0x1234_5678 next cycle. Write x0=0xFFFF_FFFF: reads 0.
- Same-cycle ports 0 and 1 both write x7 (0xAAAA_0000, 0x5555_0000) -> x7=0x5555_0000. BYPASS=1 shows 0x5555_0000 the same cycle.
- Pair write to x10 with lo=0x1, hi=0x2 -> x10=0x1, x11=0x2. Pair read of x10 returns rdata=0x1, rdata_hi=0x2.
- Pair write to x31 -> x31 updated, x0 still 0, pair_err_o=1 for exactly one cycle. FPU=1: pair write to f31 does not touch x0/f0.
- Reserve x12 with pair -> rbusy for x12/x13 = 1 next cycle. Write-back x12 and re-reserve x12 in the same cycle -> x12 stays busy, x13 stays busy. Write x13 -> x13 clears.
- Assert rst_n=0 mid-burst with writes and reservations pending -> all reads 0 and all rbusy 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/cv32e40p_register_file_mp_pkg.sv
// Shared constants and address helpers for the multi-port register file.
package cv32e40p_pkg;

    localparam int unsigned NUM_INT_REGS = 32;
    localparam int unsigned NUM_FP_REGS  = 32;
    localparam int unsigned REG_IDX_W    = 6;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t addr;
    } next_addr_t;

    // Bit 5 is the FP bank select only when an FP bank exists; otherwise it folds onto the integer bank.
    function automatic reg_idx_t regfile_map_addr(input reg_idx_t addr, input logic fp_present);
        return {fp_present & addr[5], addr[4:0]};
    endfunction

    // Second register of a pair: offset+1 inside the same bank, invalid at the bank wrap.
    function automatic next_addr_t regfile_next_addr(input reg_idx_t addr);
        next_addr_t n;
        n.valid = (addr[4:0] != 5'd31);
        n.addr  = {addr[5], addr[4:0] + 5'd1};
        return n;
    endfunction

endpackage

// File: rtl/cv32e40p_register_file_mp_if.sv
// Register file access bus: read ports, write ports and scoreboard reservation.
interface cv32e40p_register_file_mp_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RPORTS = 3,
    parameter int unsigned NUM_WPORTS = 2
);
    logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_i;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_hi_o;
    logic [NUM_RPORTS-1:0]                 rbusy_o;
    logic [NUM_RPORTS-1:0]                 rpair_i;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
    logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_hi_i;
    logic [NUM_WPORTS-1:0]                 we_i;
    logic [NUM_WPORTS-1:0]                 wpair_i;
    logic                                  res_valid_i;
    logic [ADDR_WIDTH-1:0]                 res_addr_i;
    logic                                  res_pair_i;
    logic                                  pair_err_o;

    modport master (
        output raddr_i, rpair_i, waddr_i, wdata_i, wdata_hi_i, we_i, wpair_i,
               res_valid_i, res_addr_i, res_pair_i,
        input  rdata_o, rdata_hi_o, rbusy_o, pair_err_o
    );

    modport slave (
        input  raddr_i, rpair_i, waddr_i, wdata_i, wdata_hi_i, we_i, wpair_i,
               res_valid_i, res_addr_i, res_pair_i,
        output rdata_o, rdata_hi_o, rbusy_o, pair_err_o
    );
endinterface

// File: rtl/cv32e40p_regfile_scoreboard.sv
// Per-register busy scoreboard: reservation sets, write-back clears, reservation wins.
module cv32e40p_regfile_scoreboard
    import cv32e40p_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_RPORTS = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 res_valid_i,
    input  reg_idx_t                             res_idx_i,
    input  logic                                 res_pair_i,
    input  logic [NUM_REGS-1:0]                  wr_clr_i,
    input  logic [NUM_RPORTS-1:0][REG_IDX_W-1:0] rd_idx_i,
    input  logic [NUM_RPORTS-1:0]                rpair_i,
    output logic [NUM_RPORTS-1:0]                rbusy_o
);

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   res_set;
    next_addr_t            res_hi;
    next_addr_t            rd_hi [NUM_RPORTS];
    logic [NUM_RPORTS-1:0] lo_busy;
    logic [NUM_RPORTS-1:0] hi_busy;

    // Decode the reservation (and its pair partner) into a set vector; x0 is never reserved.
    always_comb begin
        res_hi  = regfile_next_addr(res_idx_i);
        res_set = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (res_valid_i && (res_idx_i == REG_IDX_W'(r)))
                res_set[r] = 1'b1;
            if (res_valid_i && res_pair_i && res_hi.valid && (res_hi.addr == REG_IDX_W'(r)))
                res_set[r] = 1'b1;
        end
    end

    // Busy state: reservation has priority over a same-cycle write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= res_set | (busy_q & ~wr_clr_i);
    end

    // Busy lookup per read port from current state only.
    always_comb begin
        lo_busy = '0;
        hi_busy = '0;
        for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
            rd_hi[i] = regfile_next_addr(rd_idx_i[i]);
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (rd_idx_i[i] == REG_IDX_W'(r))
                    lo_busy[i] = busy_q[r];
                if (rd_hi[i].valid && (rd_hi[i].addr == REG_IDX_W'(r)))
                    hi_busy[i] = busy_q[r];
            end
        end
        rbusy_o = lo_busy | (rpair_i & hi_busy);
    end

endmodule

// File: rtl/cv32e40p_register_file_mp.sv
// Flip-flop multi-port register file with pair access, optional bypass and busy scoreboard.
module cv32e40p_register_file_mp
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FPU        = 0,
    parameter int unsigned PULP_ZFINX = 0,
    parameter int unsigned NUM_RPORTS = 3,
    parameter int unsigned NUM_WPORTS = 2,
    parameter int unsigned BYPASS     = 0
) (
    input logic                          clk,
    input logic                          rst_n,
    cv32e40p_register_file_mp_if.slave   rf
);

    localparam bit          FP_PRESENT = (FPU == 1) && (PULP_ZFINX == 0);
    localparam int unsigned NUM_REGS   = FP_PRESENT ? NUM_INT_REGS + NUM_FP_REGS : NUM_INT_REGS;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   mem_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   wr_data;
    logic [NUM_REGS-1:0]                   wr_en;
    logic [NUM_WPORTS-1:0][REG_IDX_W-1:0]  w_idx;
    next_addr_t                            w_hi [NUM_WPORTS];
    logic [NUM_RPORTS-1:0][REG_IDX_W-1:0]  r_idx;
    next_addr_t                            r_hi [NUM_RPORTS];
    reg_idx_t                              res_idx;
    next_addr_t                            res_hi;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata_hi;
    logic                                  byp_en;
    logic                                  pair_err_d;
    logic                                  pair_err_q;

    // Map all incoming addresses to bank/offset indices and their pair partners.
    always_comb begin
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            w_idx[p] = regfile_map_addr(REG_IDX_W'(rf.waddr_i[p]), FP_PRESENT);
            w_hi[p]  = regfile_next_addr(w_idx[p]);
        end
        for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
            r_idx[i] = regfile_map_addr(REG_IDX_W'(rf.raddr_i[i]), FP_PRESENT);
            r_hi[i]  = regfile_next_addr(r_idx[i]);
        end
        res_idx = regfile_map_addr(REG_IDX_W'(rf.res_addr_i), FP_PRESENT);
        res_hi  = regfile_next_addr(res_idx);
    end

    // Write decoder: ascending port scan so the highest port index wins; x0 is skipped.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (rf.we_i[p] && (w_idx[p] == REG_IDX_W'(r))) begin
                    wr_en[r]   = 1'b1;
                    wr_data[r] = rf.wdata_i[p];
                end
                if (rf.we_i[p] && rf.wpair_i[p] && w_hi[p].valid && (w_hi[p].addr == REG_IDX_W'(r))) begin
                    wr_en[r]   = 1'b1;
                    wr_data[r] = rf.wdata_hi_i[p];
                end
            end
        end
    end

    // Storage update on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                if (wr_en[r])
                    mem_q[r] <= wr_data[r];
        end
    end

    // Combinational read mux; bypass is suppressed while reset holds the array clear.
    always_comb begin
        byp_en   = (BYPASS != 0) && rst_n;
        rdata    = '0;
        rdata_hi = '0;
        for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (r_idx[i] == REG_IDX_W'(r))
                    rdata[i] = (byp_en && wr_en[r]) ? wr_data[r] : mem_q[r];
                if (r_hi[i].valid && (r_hi[i].addr == REG_IDX_W'(r)))
                    rdata_hi[i] = (byp_en && wr_en[r]) ? wr_data[r] : mem_q[r];
            end
        end
    end

    // Flag any pair read, write or reservation that would run past the end of its bank.
    always_comb begin
        pair_err_d = rf.res_valid_i & rf.res_pair_i & ~res_hi.valid;
        for (int unsigned p = 0; p < NUM_WPORTS; p++)
            pair_err_d = pair_err_d | (rf.we_i[p] & rf.wpair_i[p] & ~w_hi[p].valid);
        for (int unsigned i = 0; i < NUM_RPORTS; i++)
            pair_err_d = pair_err_d | (rf.rpair_i[i] & ~r_hi[i].valid);
    end

    // Registered pair error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pair_err_q <= 1'b0;
        else
            pair_err_q <= pair_err_d;
    end

    assign rf.rdata_o    = rdata;
    assign rf.rdata_hi_o = rdata_hi;
    assign rf.pair_err_o = pair_err_q;

    cv32e40p_regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .NUM_RPORTS (NUM_RPORTS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid_i (rf.res_valid_i),
        .res_idx_i   (res_idx),
        .res_pair_i  (rf.res_pair_i),
        .wr_clr_i    (wr_en),
        .rd_idx_i    (r_idx),
        .rpair_i     (rf.rpair_i),
        .rbusy_o     (rf.rbusy_o)
    );

endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Scoreboard bench: dut0 = integer only, no bypass; dut1 = FP bank, bypass.
module tb_cv32e40p_register_file_mp;

    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NR-1:0][5:0]   raddr;
    logic [NR-1:0]        rpair;
    logic [NW-1:0][5:0]   waddr;
    logic [NW-1:0][31:0]  wdata;
    logic [NW-1:0][31:0]  wdata_hi;
    logic [NW-1:0]        we;
    logic [NW-1:0]        wpair;
    logic                 res_valid;
    logic [5:0]           res_addr;
    logic                 res_pair;

    cv32e40p_register_file_mp_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) bus0 ();
    cv32e40p_register_file_mp_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) bus1 ();

    assign bus0.raddr_i     = raddr;
    assign bus0.rpair_i     = rpair;
    assign bus0.waddr_i     = waddr;
    assign bus0.wdata_i     = wdata;
    assign bus0.wdata_hi_i  = wdata_hi;
    assign bus0.we_i        = we;
    assign bus0.wpair_i     = wpair;
    assign bus0.res_valid_i = res_valid;
    assign bus0.res_addr_i  = res_addr;
    assign bus0.res_pair_i  = res_pair;
    assign bus1.raddr_i     = raddr;
    assign bus1.rpair_i     = rpair;
    assign bus1.waddr_i     = waddr;
    assign bus1.wdata_i     = wdata;
    assign bus1.wdata_hi_i  = wdata_hi;
    assign bus1.we_i        = we;
    assign bus1.wpair_i     = wpair;
    assign bus1.res_valid_i = res_valid;
    assign bus1.res_addr_i  = res_addr;
    assign bus1.res_pair_i  = res_pair;

    cv32e40p_register_file_mp #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(0), .PULP_ZFINX(0),
        .NUM_RPORTS(NR), .NUM_WPORTS(NW), .BYPASS(0)
    ) dut0 (.clk(clk), .rst_n(rst_n), .rf(bus0));

    cv32e40p_register_file_mp #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .PULP_ZFINX(0),
        .NUM_RPORTS(NR), .NUM_WPORTS(NW), .BYPASS(1)
    ) dut1 (.clk(clk), .rst_n(rst_n), .rf(bus1));

    // Reference model: [dut][bank][offset]
    logic [31:0] m_reg  [2][2][32];
    bit          m_busy [2][2][32];
    bit          m_err  [2];

    typedef struct packed {
        logic [1:0][NR-1:0][31:0] rd;
        logic [1:0][NR-1:0][31:0] rh;
        logic [1:0][NR-1:0]       rb;
        logic [1:0]               err;
    } exp_t;

    exp_t exp_q[$];
    event pushed;
    int   total = 0;
    int   bad   = 0;

    function automatic int bank_of(int d, logic [5:0] a);
        return (d == 1) ? int'(a[5]) : 0;
    endfunction

    function automatic logic [31:0] peek(int d, int b, int o);
        logic [31:0] v;
        int wb, wo;
        if (b == 0 && o == 0) return 32'h0;
        v = m_reg[d][b][o];
        if (d == 1 && rst_n) begin
            for (int p = 0; p < NW; p++) begin
                if (we[p]) begin
                    wb = bank_of(d, waddr[p]);
                    wo = int'(waddr[p][4:0]);
                    if (wb == b && wo == o) v = wdata[p];
                    if (wpair[p] && wo < 31 && wb == b && wo + 1 == o) v = wdata_hi[p];
                end
            end
        end
        return v;
    endfunction

    function automatic exp_t build();
        exp_t e;
        int b, o;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NR; i++) begin
                b = bank_of(d, raddr[i]);
                o = int'(raddr[i][4:0]);
                if (rst_n) begin
                    e.rd[d][i] = peek(d, b, o);
                    e.rh[d][i] = (o == 31) ? 32'h0 : peek(d, b, o + 1);
                    e.rb[d][i] = m_busy[d][b][o] | (rpair[i] && o < 31 && m_busy[d][b][(o + 1) % 32]);
                end
            end
            e.err[d] = rst_n ? m_err[d] : 1'b0;
        end
        return e;
    endfunction

    task automatic model_edge();
        int b, o;
        bit ne;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int bb = 0; bb < 2; bb++)
                    for (int k = 0; k < 32; k++) begin
                        m_reg[d][bb][k]  = 32'h0;
                        m_busy[d][bb][k] = 1'b0;
                    end
                m_err[d] = 1'b0;
            end else begin
                ne = 1'b0;
                for (int i = 0; i < NR; i++)
                    if (rpair[i] && raddr[i][4:0] == 5'd31) ne = 1'b1;
                for (int p = 0; p < NW; p++)
                    if (we[p] && wpair[p] && waddr[p][4:0] == 5'd31) ne = 1'b1;
                if (res_valid && res_pair && res_addr[4:0] == 5'd31) ne = 1'b1;
                for (int p = 0; p < NW; p++) begin
                    if (we[p]) begin
                        b = bank_of(d, waddr[p]);
                        o = int'(waddr[p][4:0]);
                        if (!(b == 0 && o == 0)) begin
                            m_reg[d][b][o]  = wdata[p];
                            m_busy[d][b][o] = 1'b0;
                        end
                        if (wpair[p] && o < 31) begin
                            m_reg[d][b][o + 1]  = wdata_hi[p];
                            m_busy[d][b][o + 1] = 1'b0;
                        end
                    end
                end
                if (res_valid) begin
                    b = bank_of(d, res_addr);
                    o = int'(res_addr[4:0]);
                    if (!(b == 0 && o == 0)) m_busy[d][b][o] = 1'b1;
                    if (res_pair && o < 31) m_busy[d][b][o + 1] = 1'b1;
                end
                m_err[d] = ne;
            end
        end
    endtask

    task automatic issue();
        exp_q.push_back(build());
        -> pushed;
    endtask

    task automatic step();
        issue();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_wr();
        we = '0; wpair = '0; res_valid = 1'b0; res_pair = 1'b0;
        waddr = '0; wdata = '0; wdata_hi = '0; res_addr = '0;
    endtask

    task automatic chk(string nm, int d, int i, logic [31:0] got, logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s dut%0d port%0d t=%0t got=%h exp=%h", nm, d, i, $time, got, expv);
        end
    endtask

    // Monitor: compares DUT outputs against each queued expectation shortly after it is issued.
    initial begin
        exp_t e;
        forever begin
            @(pushed);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NR; i++) begin
                    chk("rdata",    0, i, bus0.rdata_o[i],           e.rd[0][i]);
                    chk("rdata_hi", 0, i, bus0.rdata_hi_o[i],        e.rh[0][i]);
                    chk("rbusy",    0, i, 32'(bus0.rbusy_o[i]),      32'(e.rb[0][i]));
                    chk("rdata",    1, i, bus1.rdata_o[i],           e.rd[1][i]);
                    chk("rdata_hi", 1, i, bus1.rdata_hi_o[i],        e.rh[1][i]);
                    chk("rbusy",    1, i, 32'(bus1.rbusy_o[i]),      32'(e.rb[1][i]));
                end
                chk("pair_err", 0, 0, 32'(bus0.pair_err_o), 32'(e.err[0]));
                chk("pair_err", 1, 0, 32'(bus1.pair_err_o), 32'(e.err[1]));
            end
        end
    end

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 6'd31;
            1: return 6'd63;
            2: return 6'd32;
            3: return 6'd0;
            default: return 6'($urandom_range(0, 15) + 32 * $urandom_range(0, 1));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        raddr = '0; rpair = '0;
        idle_wr();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write with read of same register, then x0 write.
        raddr[0] = 6'd5; raddr[1] = 6'd0;
        we[0] = 1'b1; waddr[0] = 6'd5; wdata[0] = 32'h1234_5678;
        step(); idle_wr(); step();
        we[0] = 1'b1; waddr[0] = 6'd0; wdata[0] = 32'hFFFF_FFFF;
        step(); idle_wr(); step();

        // Two ports writing the same register.
        raddr[0] = 6'd7;
        we = 2'b11; waddr[0] = 6'd7; waddr[1] = 6'd7;
        wdata[0] = 32'hAAAA_0000; wdata[1] = 32'h5555_0000;
        step(); idle_wr(); step();

        // Pair write and pair read.
        raddr[0] = 6'd10; rpair[0] = 1'b1;
        we[0] = 1'b1; wpair[0] = 1'b1; waddr[0] = 6'd10; wdata[0] = 32'h1; wdata_hi[0] = 32'h2;
        step(); idle_wr(); step();

        // Pair write at the bank wrap, integer then FP bank (aliases integer on dut0).
        raddr[0] = 6'd31; raddr[1] = 6'd0; raddr[2] = 6'd32; rpair = '0;
        we[0] = 1'b1; wpair[0] = 1'b1; waddr[0] = 6'd31; wdata[0] = 32'hDEAD_0031; wdata_hi[0] = 32'hBAD0_0000;
        step(); idle_wr(); step(); step();
        raddr[0] = 6'd63;
        we[0] = 1'b1; wpair[0] = 1'b1; waddr[0] = 6'd63; wdata[0] = 32'hCAFE_0063; wdata_hi[0] = 32'hBAD1_0000;
        step(); idle_wr(); step(); step();

        // Scoreboard: pair reserve, write-back with re-reserve, then clear the partner.
        raddr[0] = 6'd12; raddr[1] = 6'd13; raddr[2] = 6'd12; rpair[2] = 1'b1;
        res_valid = 1'b1; res_addr = 6'd12; res_pair = 1'b1;
        step(); idle_wr(); step();
        we[0] = 1'b1; waddr[0] = 6'd12; wdata[0] = 32'h0000_0C0C;
        res_valid = 1'b1; res_addr = 6'd12;
        step(); idle_wr(); step();
        we[1] = 1'b1; waddr[1] = 6'd13; wdata[1] = 32'h0000_0D0D;
        step(); idle_wr(); step();

        // Reset asserted mid-cycle with writes and reservations pending.
        raddr[0] = 6'd5; raddr[1] = 6'd7; raddr[2] = 6'd12; rpair = 3'b100;
        we = 2'b11; waddr[0] = 6'd5; waddr[1] = 6'd12; wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
        res_valid = 1'b1; res_addr = 6'd7; res_pair = 1'b1;
        issue();
        #2;
        rst_n = 1'b0;
        issue();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
        idle_wr();
        step();
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                raddr[i] = pick_addr();
                rpair[i] = ($urandom_range(0, 3) == 0);
            end
            for (int p = 0; p < NW; p++) begin
                we[p]       = ($urandom_range(0, 2) != 0);
                wpair[p]    = ($urandom_range(0, 2) == 0);
                waddr[p]    = pick_addr();
                wdata[p]    = $urandom;
                wdata_hi[p] = $urandom;
            end
            res_valid = ($urandom_range(0, 2) == 0);
            res_pair  = ($urandom_range(0, 1) == 0);
            res_addr  = pick_addr();
            step();
        end

        idle_wr();
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
